// File: rtl/param_sync_bank.sv
// ============================================================================
// Module   : param_sync_bank
// Purpose  : Brings NUM_CH asynchronous parameter words and the machine
//            start/stop acknowledges into the clk domain. Each captured word
//            is range-clamped into a shadow register and committed to the
//            live output immediately when idle, or only on a pulse-cycle
//            boundary while machining.
// Ports    : clk, sys_rst           - clock, synchronous active-high reset
//            machine_start_ack_i   - async start ack (rise sets is_machine)
//            machine_stop_ack_i    - async stop ack (rise clears is_machine)
//            change_ack_i          - async per-channel change ack
//            data_async_i          - per-channel words, stable while ack high
//            cycle_boundary_i      - end-of-period pulse from pulse generator
//            clear_flags_i         - clears the sticky flags
//            is_machine_o          - machining enable
//            data_out_o            - live committed parameters
//            pending_o             - shadow holds an uncommitted value
//            update_done_o         - one-cycle pulse on commit
//            clamp_flag_o          - sticky: a captured value was clamped
//            overrun_flag_o        - sticky: capture while already pending
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_sync_bank #(
    parameter int                       NUM_CH      = 4,
    parameter int                       DATA_W      = 16,
    parameter int                       SYNC_STAGES = 3,   // must be >= 2
    parameter logic [NUM_CH*DATA_W-1:0] MIN_VAL     = '0,
    parameter logic [NUM_CH*DATA_W-1:0] MAX_VAL     = '1,
    parameter logic [NUM_CH*DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                     clk,
    input  logic                     sys_rst,
    input  logic                     machine_start_ack_i,
    input  logic                     machine_stop_ack_i,
    input  logic [NUM_CH-1:0]        change_ack_i,
    input  logic [NUM_CH*DATA_W-1:0] data_async_i,
    input  logic                     cycle_boundary_i,
    input  logic                     clear_flags_i,
    output logic                     is_machine_o,
    output logic [NUM_CH*DATA_W-1:0] data_out_o,
    output logic [NUM_CH-1:0]        pending_o,
    output logic [NUM_CH-1:0]        update_done_o,
    output logic [NUM_CH-1:0]        clamp_flag_o,
    output logic [NUM_CH-1:0]        overrun_flag_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_t;

    localparam int NUM_ACK = NUM_CH + 2;
    localparam int START_IDX = NUM_CH;
    localparam int STOP_IDX  = NUM_CH + 1;

    logic [NUM_ACK-1:0] ack_all;
    logic [NUM_ACK-1:0] rise;
    logic               is_machine_q;
    logic               is_machine_d;

    assign ack_all = {machine_stop_ack_i, machine_start_ack_i, change_ack_i};

    // Synchroniser chain plus one extra flop; a rise is the last stage high
    // while its delayed copy is still low, so a held level yields one rise.
    for (genvar a = 0; a < NUM_ACK; a++) begin : g_sync
        logic [SYNC_STAGES:0] sync_q;

        always_ff @(posedge clk) begin
            if (sys_rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-1:0], ack_all[a]};
            end
        end

        assign rise[a] = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    end

    // Stop is checked first so simultaneous rises leave the machine stopped.
    always_comb begin
        is_machine_d = is_machine_q;
        if (rise[STOP_IDX]) begin
            is_machine_d = 1'b0;
        end else if (rise[START_IDX]) begin
            is_machine_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            is_machine_q <= 1'b0;
        end else begin
            is_machine_q <= is_machine_d;
        end
    end

    assign is_machine_o = is_machine_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DATA_W-1:0] raw;
        logic [DATA_W-1:0] lo_lim;
        logic [DATA_W-1:0] hi_lim;
        logic [DATA_W-1:0] floored;
        logic [DATA_W-1:0] clamped;
        logic              commit;
        state_t            state_q, state_d;
        logic [DATA_W-1:0] shadow_q, shadow_d;
        logic [DATA_W-1:0] data_q, data_d;
        logic              done_q, done_d;
        logic              clamp_q, clamp_d;
        logic              ovr_q, ovr_d;

        assign raw    = data_async_i[i*DATA_W +: DATA_W];
        assign lo_lim = MIN_VAL[i*DATA_W +: DATA_W];
        assign hi_lim = MAX_VAL[i*DATA_W +: DATA_W];

        // Lower limit applied before upper so a misconfigured channel
        // (MIN > MAX) always resolves to MAX.
        assign floored = (raw < lo_lim) ? lo_lim : raw;
        assign clamped = (floored > hi_lim) ? hi_lim : floored;

        always_comb begin
            state_d  = state_q;
            shadow_d = shadow_q;
            data_d   = data_q;
            done_d   = 1'b0;
            clamp_d  = clamp_q & ~clear_flags_i;
            ovr_d    = ovr_q & ~clear_flags_i;
            commit   = (state_q == S_PEND) && (!is_machine_q || cycle_boundary_i);

            if (commit) begin
                data_d  = shadow_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            // A rise on the commit edge re-arms the shadow after the old
            // value has been committed, so it is not an overrun.
            if (rise[i]) begin
                shadow_d = clamped;
                state_d  = S_PEND;
                if (clamped != raw) begin
                    clamp_d = 1'b1;
                end
                if ((state_q == S_PEND) && !commit) begin
                    ovr_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (sys_rst) begin
                state_q  <= S_IDLE;
                shadow_q <= '0;
                data_q   <= RESET_VAL[i*DATA_W +: DATA_W];
                done_q   <= 1'b0;
                clamp_q  <= 1'b0;
                ovr_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                shadow_q <= shadow_d;
                data_q   <= data_d;
                done_q   <= done_d;
                clamp_q  <= clamp_d;
                ovr_q    <= ovr_d;
            end
        end

        assign data_out_o[i*DATA_W +: DATA_W] = data_q;
        assign pending_o[i]      = (state_q == S_PEND);
        assign update_done_o[i]  = done_q;
        assign clamp_flag_o[i]   = clamp_q;
        assign overrun_flag_o[i] = ovr_q;
    end

endmodule

`default_nettype wire
